// File: rtl/dac_handler_if.sv
// -----------------------------------------------------------------------------
// dac_handler_if
// Sample hand-off bus between the upstream sample source (FIR output) and the
// DAC serialiser.
//   sample_data  [11:0]  sample to convert (source -> serialiser)
//   sample_valid         sample_data is valid (source -> serialiser)
//   sample_ready         serialiser can accept a sample (serialiser -> source)
// A transfer happens on a clock edge where sample_valid & sample_ready.
// Modports: master = upstream source, slave = dac_handler.
// -----------------------------------------------------------------------------
interface dac_handler_if;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/dac_handler.sv
// -----------------------------------------------------------------------------
// dac_handler
// Serial transmit path for a DAC7311-class 12-bit SPI DAC. One 12-bit sample is
// taken per valid/ready handshake and sent as a 16-bit frame, MSB first:
//   {2'b00 (normal power mode), data[11:0], 2'b00}
//
// Parameters
//   CLK_DIV     sclk half-period in sys_clk cycles (>=1)
//   GAP_CYCLES  minimum sync_n high time between frames, in sys_clk cycles (>=1)
//
// Build option
//   DAC_OFFSET_BIN_EN  when defined, sample_data is two's complement and bit 11
//                      is inverted at latch time to give offset binary.
//                      When undefined, sample_data is straight binary.
//
// Ports
//   sys_clk     system clock (only clock in the block)
//   rst_n       asynchronous active-low reset
//   smp         sample bus (slave side): sample_data, sample_valid, sample_ready
//   sclk        DAC serial clock, idles high
//   sync_n      DAC frame sync, active low
//   din         DAC serial data; DAC samples it on sclk falling edges
//   frame_done  one-cycle pulse as sync_n rises at the end of a full frame
//
// Frame timing: sync_n is low for 33*CLK_DIV cycles (one setup half-period,
// 16 low and 16 high sclk half-periods). After it rises, GAP_CYCLES cycles pass
// before sample_ready returns high.
// -----------------------------------------------------------------------------
module dac_handler #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  dac_handler_if.slave smp,
  output logic         sclk,
  output logic         sync_n,
  output logic         din,
  output logic         frame_done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;     // position inside the current sclk half-period
  logic [GAP_W-1:0] gap_q;     // cycles spent in GAP
  logic [3:0]       bit_q;     // sclk falling edges seen in this frame, minus one
  logic [14:0]      shreg_q;   // frame bits still to be driven, next bit at [14]
  logic             sclk_q;
  logic             sync_n_q;
  logic             din_q;
  logic             ready_q;
  logic             done_q;

  logic [11:0]      data_fmt_d;
  logic [15:0]      frame_d;

  // Frame assembled from the live bus value; only used on the accept edge.
  always_comb begin
    data_fmt_d = smp.sample_data;
`ifdef DAC_OFFSET_BIN_EN
    data_fmt_d[11] = ~smp.sample_data[11];
`else
`endif
    frame_d = {2'b00, data_fmt_d, 2'b00};
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      // Start in GAP so sample_ready rises GAP_CYCLES after reset release.
      state_q  <= S_GAP;
      div_q    <= '0;
      gap_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      din_q    <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (smp.sample_valid && ready_q) begin
            state_q  <= S_SETUP;
            sync_n_q <= 1'b0;
            din_q    <= frame_d[15];
            shreg_q  <= frame_d[14:0];
            ready_q  <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
          end
        end

        S_SETUP: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            sclk_q  <= 1'b0;
            state_q <= S_SHIFT;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (!sclk_q) begin
              // End of a low phase: rising edge. din moves on to the next bit
              // except after the 16th bit, where it holds frame[0].
              sclk_q <= 1'b1;
              if (bit_q != BIT_LAST) begin
                din_q   <= shreg_q[14];
                shreg_q <= {shreg_q[13:0], 1'b0};
              end
            end else if (bit_q == BIT_LAST) begin
              // Final high phase done: close the frame.
              sync_n_q <= 1'b1;
              din_q    <= 1'b0;
              done_q   <= 1'b1;
              gap_q    <= '0;
              state_q  <= S_GAP;
            end else begin
              sclk_q <= 1'b0;
              bit_q  <= bit_q + 4'd1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        default: begin
          state_q  <= S_GAP;
          gap_q    <= '0;
          sclk_q   <= 1'b1;
          sync_n_q <= 1'b1;
          din_q    <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign smp.sample_ready = ready_q;
  assign sclk             = sclk_q;
  assign sync_n           = sync_n_q;
  assign din              = din_q;
  assign frame_done       = done_q;

endmodule

// File: tb/tb_dac_handler.sv
// -----------------------------------------------------------------------------
// tb_dac_handler
// Bench for dac_handler. A timeline model predicts every output from the number
// of clock edges since the last accept (or reset release); a monitor rebuilds
// the frames the DAC would see on sclk falling edges and measures run lengths.
// -----------------------------------------------------------------------------
module tb_dac_handler;

  localparam int unsigned D = 4;
  localparam int unsigned G = 4;
  localparam int          L = 33 * int'(D);

`ifdef DAC_OFFSET_BIN_EN
  localparam logic [15:0] F_A5C = 16'h0970;
  localparam logic [15:0] F_000 = 16'h2000;
  localparam logic [15:0] F_001 = 16'h2004;
  localparam logic [15:0] F_002 = 16'h2008;
  localparam logic [15:0] F_003 = 16'h200C;
  localparam logic [15:0] F_123 = 16'h248C;
  localparam logic [15:0] F_FFF = 16'h1FFC;
  localparam logic [15:0] F_800 = 16'h0000;
`else
  localparam logic [15:0] F_A5C = 16'h2970;
  localparam logic [15:0] F_000 = 16'h0000;
  localparam logic [15:0] F_001 = 16'h0004;
  localparam logic [15:0] F_002 = 16'h0008;
  localparam logic [15:0] F_003 = 16'h000C;
  localparam logic [15:0] F_123 = 16'h048C;
  localparam logic [15:0] F_FFF = 16'h3FFC;
  localparam logic [15:0] F_800 = 16'h2000;
`endif

  logic sys_clk = 1'b0;
  logic rst_n;
  logic sclk, sync_n, din, frame_done;

  dac_handler_if bus ();

  dac_handler #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .smp        (bus.slave),
    .sclk       (sclk),
    .sync_n     (sync_n),
    .din        (din),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int nprint = 0;

  // ---------------------------------------------------------------- model
  function automatic logic [15:0] mk_frame(logic [11:0] d);
    logic [11:0] v;
    v = d;
`ifdef DAC_OFFSET_BIN_EN
    v[11] = ~v[11];
`endif
    return {2'b00, v, 2'b00};
  endfunction

  // mode 0: t = edges since reset release; mode 1: t = edges since accept edge
  int          m_mode = 0;
  int          m_t    = 0;
  logic [15:0] m_frame = '0;
  int          m_acc  = 0;

  function automatic bit m_ready_f(int mode, int t);
    return (mode == 0) ? (t >= int'(G)) : (t >= L + int'(G));
  endfunction

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_t    <= 0;
    end else if (bus.sample_valid === 1'b1 && m_ready_f(m_mode, m_t)) begin
      m_mode  <= 1;
      m_t     <= 0;
      m_frame <= mk_frame(bus.sample_data);
      m_acc   <= m_acc + 1;
    end else if (m_t < 1000000) begin
      m_t <= m_t + 1;
    end
  end

  // Per-cycle compare of all outputs against the timeline model.
  always @(negedge sys_clk) begin
    logic e_sclk, e_sync, e_din, e_rdy, e_done;
    int p, bi;
    e_sclk = 1'b1; e_sync = 1'b1; e_din = 1'b0; e_done = 1'b0;
    e_rdy  = m_ready_f(m_mode, m_t);
    if (m_mode == 1 && m_t < L) begin
      e_sync = 1'b0;
      p      = m_t / int'(D);
      e_sclk = (p % 2 == 0);
      bi     = 15 - p / 2;
      if (bi < 0) bi = 0;
      e_din  = m_frame[bi];
    end else if (m_mode == 1 && m_t == L) begin
      e_done = 1'b1;
    end
    total++;
    if ({sclk, sync_n, din, bus.sample_ready, frame_done} !==
        {e_sclk, e_sync, e_din, e_rdy, e_done}) begin
      bad++;
      if (nprint < 20) begin
        nprint++;
        $display("FAIL cycle_cmp @%0t: got sclk,sync_n,din,ready,done=%b%b%b%b%b expected %b%b%b%b%b",
                 $time, sclk, sync_n, din, bus.sample_ready, frame_done,
                 e_sclk, e_sync, e_din, e_rdy, e_done);
      end
    end
  end

  // -------------------------------------------------------------- monitor
  logic        pv_sclk = 1'b1, pv_sync = 1'b1, pv_rdy = 1'b0;
  logic [15:0] sh = '0;
  int nb = 0, sync_low_run = 0, sync_high_run = 0, rdy_low_run = 0;
  int last_sync_low = 0, last_rdy_low = 0, done_cnt = 0;
  logic [15:0] frames[$];
  int          gaps[$];

  always @(negedge sys_clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (!rst_n) begin
      nb = 0; sh = '0; sync_low_run = 0; sync_high_run = 0; rdy_low_run = 0;
      pv_sclk = 1'b1; pv_sync = 1'b1; pv_rdy = 1'b0;
    end else begin
      if (sync_n === 1'b0) begin
        if (pv_sync) begin
          gaps.push_back(sync_high_run);
          nb = 0; sh = '0; sync_low_run = 0;
        end
        sync_low_run++;
        if (pv_sclk && sclk === 1'b0) begin
          sh = {sh[14:0], din};
          nb++;
        end
      end else begin
        if (!pv_sync) begin
          last_sync_low = sync_low_run;
          if (nb == 16) frames.push_back(sh);
          sync_high_run = 0;
        end
        sync_high_run++;
      end
      if (bus.sample_ready !== 1'b1) rdy_low_run++;
      else if (!pv_rdy) begin
        last_rdy_low = rdy_low_run;
        rdy_low_run  = 0;
      end
      pv_sclk = sclk; pv_sync = sync_n; pv_rdy = bus.sample_ready;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int fget(int i);
    return (i < frames.size()) ? int'(frames[i]) : -1;
  endfunction

  function automatic int gget(int i);
    return (i < gaps.size()) ? gaps[i] : -1;
  endfunction

  task automatic idle(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send(logic [11:0] d, bit hold);
    int n;
    int a0;
    n  = 0;
    a0 = m_acc;
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
    while (m_acc == a0 && n < 400) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (m_acc == a0) check("accept_timeout", 0, 1);
    if (!hold) bus.sample_valid = 1'b0;
  endtask

  task automatic wait_frames(int cnt);
    int n;
    n = 0;
    while (frames.size() < cnt && n < 2000) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    if (frames.size() < cnt) check("frame_timeout", frames.size(), cnt);
  endtask

  task automatic wait_ready(string name, int exp);
    int n;
    n = 0;
    while (bus.sample_ready !== 1'b1 && n < 50) begin
      @(posedge sys_clk);
      #1;
      n++;
    end
    check(name, n, exp);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int d0;
    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;

    // Reset values
    idle(3);
    check("rst_sclk",   int'(sclk), 1);
    check("rst_sync_n", int'(sync_n), 1);
    check("rst_din",    int'(din), 0);
    check("rst_ready",  int'(bus.sample_ready), 0);
    check("rst_done",   int'(frame_done), 0);
    rst_n = 1'b1;
    wait_ready("ready_after_reset", 4);

    // Single sample 0xA5C
    frames.delete();
    d0 = done_cnt;
    send(12'hA5C, 1'b0);
    wait_frames(1);
    idle(int'(G) + 2);
    check("frame_A5C",     fget(0), int'(F_A5C));
    check("sync_low_len",  last_sync_low, 132);
    check("ready_low_len", last_rdy_low, 136);
    check("done_pulses",   done_cnt - d0, 1);

    // Zero sample
    frames.delete();
    send(12'h000, 1'b0);
    wait_frames(1);
    idle(int'(G) + 2);
    check("frame_000", fget(0), int'(F_000));

    // valid held high, data stepping after each accept
    frames.delete();
    gaps.delete();
    send(12'h001, 1'b1);
    send(12'h002, 1'b1);
    send(12'h003, 1'b0);
    wait_frames(3);
    idle(int'(G) + 2);
    check("b2b_count",   frames.size(), 3);
    check("b2b_frame0",  fget(0), int'(F_001));
    check("b2b_frame1",  fget(1), int'(F_002));
    check("b2b_frame2",  fget(2), int'(F_003));
    check("b2b_gap1",    gget(1), int'(G) + 1);
    check("b2b_gap2",    gget(2), int'(G) + 1);

    // Data change while busy: new value waits for its own accept
    frames.delete();
    send(12'h123, 1'b0);
    idle(20);
    send(12'hFFF, 1'b0);
    wait_frames(2);
    idle(int'(G) + 2);
    check("mid_frame0", fget(0), int'(F_123));
    check("mid_frame1", fget(1), int'(F_FFF));

    // Reset during bit 7 (low phase of the 8th bit)
    frames.delete();
    d0 = done_cnt;
    send(12'h5A5, 1'b0);
    idle(15 * int'(D) + 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_sclk",   int'(sclk), 1);
    check("abort_sync_n", int'(sync_n), 1);
    check("abort_din",    int'(din), 0);
    idle(3);
    check("abort_no_done",  done_cnt - d0, 0);
    check("abort_no_frame", frames.size(), 0);
    rst_n = 1'b1;
    wait_ready("ready_after_abort", 4);
    send(12'h800, 1'b0);
    wait_frames(1);
    idle(int'(G) + 2);
    check("frame_800", fget(0), int'(F_800));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_handler.md
Name: dac_handler

Overview:
- Serial output interface for a TI DAC7311-class 12-bit SPI DAC. It is the transmit-side counterpart of the ADC capture path: filtered samples leave the FPGA through this block.
- Accepts one 12-bit sample per valid/ready handshake and serialises it as a 16-bit frame on sclk/sync_n/din.
- Sits between the FIR filter output and the DAC pins, clocked from the 100 MHz system clock.

Parameters:
- CLK_DIV, 4, sclk half-period in sys_clk cycles (>=1); default gives 12.5 MHz sclk.
- GAP_CYCLES, 4, minimum sync_n high time between frames, in sys_clk cycles (>=1).

Ports:
- sys_clk  input  1  system clock, 100 MHz; the only clock in the block
- rst_n  input  1  asynchronous active-low reset
- sample_data  input  12  sample to convert
- sample_valid  input  1  sample_data is valid
- sample_ready  output  1  block can accept a sample
- sclk  output  1  DAC serial clock; idles high
- sync_n  output  1  DAC frame sync, active low
- din  output  1  DAC serial data, MSB first
- frame_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async, rst_n=0):
  - sclk=1, sync_n=1, din=0, sample_ready=0, frame_done=0.
  - State=GAP with gap counter cleared, so sample_ready rises GAP_CYCLES after rst_n deasserts.
- Frame format (16 bits, MSB first): {2'b00 power-down bits, data[11:0], 2'b00}. Example: data 0xA5C gives frame 0x2970.
- Handshake:
  - Accept occurs on a sys_clk edge with sample_valid & sample_ready.
  - sample_data is latched at accept; later changes are ignored until the next accept.
  - sample_ready is high only in IDLE.
- All outputs are registered. States:
  - IDLE: sample_ready=1, sync_n=1, sclk=1. On accept, in the same edge: go to SETUP, sync_n<=0, din<=frame[15], sample_ready<=0.
  - SETUP: sync_n low, sclk high for CLK_DIV cycles, then sclk<=0 and go to SHIFT.
  - SHIFT:
    - sclk toggles every CLK_DIV cycles.
    - The DAC samples din on each sclk falling edge.
    - On each sclk rising edge, din advances to the next bit.
    - A 4-bit bit counter counts falling edges.
    - After the 16th low phase, sclk<=1. After that final high phase (CLK_DIV cycles), sync_n<=1, frame_done<=1 for one cycle, and the block goes to GAP.
    - din holds frame[0] until sync_n rises, then goes to 0.
  - GAP: sync_n high for GAP_CYCLES cycles, then sample_ready<=1 and go to IDLE.
- Timing:
  - sync_n is low for exactly 33*CLK_DIV cycles.
  - sample_ready is low for 33*CLK_DIV+GAP_CYCLES cycles after accept (136 with defaults).
  - Maximum throughput is one sample per 33*CLK_DIV+GAP_CYCLES+1 cycles.
- Boundary conditions:
  - sample_valid held high continuously: back-to-back frames, each separated by GAP_CYCLES+1 cycles of sync_n high.
  - sample_valid asserted while busy: no accept and no data loss; the upstream holds the sample.
  - Reset mid-frame: outputs return to reset values immediately; a partial frame is aborted by the sync_n rise, which the DAC ignores.
  - CLK_DIV=1: sclk = sys_clk/2; all rules above still hold.
- Counters: the half-period counter is wide enough for CLK_DIV-1 and the gap counter wide enough for GAP_CYCLES-1. Use $clog2, minimum 1 bit.

Optional Feature:
- Macro: DAC_OFFSET_BIN_EN.
- Defined: sample_data is treated as signed two's complement (FIR output). The block inverts bit 11 at latch time, giving offset binary (0x000 maps to mid-scale 0x800).
- Undefined: sample_data is straight binary and is passed unchanged.
- Timing and handshake are identical in both builds.

Test Plan:
- Reset release, defaults: sample_ready rises exactly 4 cycles after rst_n goes high; sclk=1, sync_n=1 throughout.
- Single sample 0xA5C, macro undefined:
  - Bits 0x2970 are captured on the 16 sclk falling edges.
  - sync_n is low 132 cycles.
  - frame_done pulses once as sync_n rises.
  - sample_ready is low 136 cycles.
- Macro defined, samples 0xA5C and 0x000:
  - 0xA5C is captured as frame 0x0970.
  - 0x000 is captured as frame 0x2000.
- sample_valid held high with data stepping 0x001, 0x002, 0x003: three frames, 0x0004, 0x0008 and 0x000C, each separated by exactly 5 cycles of sync_n high; no sample is dropped or duplicated.
- sample_data changed mid-frame from 0x123 to 0xFFF: the in-flight frame is still 0x048C; 0xFFF is sent only after its own accept.
- rst_n pulsed low during bit 7 of a frame:
  - sync_n=1, sclk=1 and din=0 asynchronously.
  - frame_done never pulses.
  - After release, a new sample 0x800 goes out as frame 0x2000 cleanly.
